seg_capture: RTL
================

# seg_capture

Seven-segment scan decoder: the receiving end of the multiplexed `seg`/`an`/`dp` display bus that the game blocks drive on the Basys3.
- Samples the time-multiplexed bus, waits for each digit's dwell to settle, and decodes the active-low segment pattern back to a hex nibble.
- Publishes a coherent 4-digit frame once every anode slot has been seen.
- Used as an on-chip self-check and as the bench's display monitor; sits in parallel with the board pins, on the same 100 MHz `clk`.

## Interface
- `SETTLE`, 16: consecutive identical samples required before a dwell is accepted; range 2..255.
- `TIMEOUT`, 4_000_000: cycles without a completed frame before `stale` asserts.
- `TW`, 23: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `seg`  in  7  segment lines, active-low; `seg[0]`=a … `seg[6]`=g.
- `an`  in  4  anode enables, active-low; `an[0]` = rightmost digit.
- `dp`  in  1  decimal point, active-low.
- `digits`  out  16  frame hex values; `digits[4i+3:4i]` = digit i.
- `dps`  out  4  decimal point lit, per digit, active-high.
- `blank`  out  4  digit i was fully dark (`seg`=7'h7F).
- `bad`  out  4  digit i pattern not in decode table.
- `frame_valid`  out  1  one-cycle pulse; frame outputs were just updated.
- `an_err`  out  1  one-cycle pulse; a settled dwell had more than one anode low.
- `stale`  out  1  no frame completed for `TIMEOUT` cycles.

## Operation
- Input stage: `{an,seg,dp}` registered every cycle into `s_q`. Previous value held in `s_p`.
- Settle counter `cnt` (8 bit):
  - If `s_q != s_p`, `cnt` <= 0.
  - Otherwise `cnt` increments, saturating at `SETTLE`.
  - Accept strobe fires only on the cycle `cnt` transitions `SETTLE-1` -> `SETTLE`, so each dwell is accepted exactly once.
- On accept, action depends on the number of low bits in `an`:
  - Exactly one low: capture into the slot of that anode (see below).
  - None low: idle/blanking interval; no action.
  - Two or more low: pulse `an_err`; no capture.
- Slot capture:
  - Shadow registers for slot i are written: nibble, dp lit (`~dp`), blank flag, bad flag.
  - `seen[i]` <= 1.
  - A slot written again before the frame completes is overwritten; last value wins.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111: blank=1, nibble=0.
  - Any other pattern: bad=1, nibble=0.
- Frame completion:
  - When the capture makes `seen` = 4'b1111, all shadow values are copied to `digits`/`dps`/`blank`/`bad` on the next edge.
  - `frame_valid` pulses on that same edge, and `seen` clears.
  - Outputs hold between frames; they never show a partial frame.
- Stale counter:
  - Cleared on `frame_valid`; otherwise increments, saturating at `TIMEOUT`.
  - `stale` = (counter == `TIMEOUT`); it drops on the cycle after the next `frame_valid`.

## Timing
- Reset values: `digits`=0, `dps`=0, `blank`=0, `bad`=0, `frame_valid`=0, `an_err`=0, `stale`=0. Also `seen`=0, `cnt`=0, stale counter=0.
- Reset asserted mid-dwell or mid-frame discards shadow content. Capture restarts from scratch after release.
- Capture latency: inputs constant from edge k are in `s_q` at k+1. The accept strobe is high in cycle k+SETTLE+1, and the slot is written at edge k+SETTLE+2.
  - If this completes the frame, outputs and `frame_valid` appear one edge later, at k+SETTLE+3.
- A dwell shorter than `SETTLE+1` cycles is never captured. This also covers glitches during anode changeover.
- An input change on the same cycle as a would-be accept cancels it; `cnt` resets.
- `an_err` and `frame_valid` cannot both fire on the same cycle, since they come from different accept outcomes.

## Test plan
- Digit capture and frame: drive dwells of 100 cycles for an=1110/1101/1011/0111 with patterns for 1,2,3,4 (dp off). Expect one `frame_valid` pulse after the 4th dwell, `digits`=16'h4321, `dps`=0, `blank`=0, `bad`=0.
- Glitch rejection (`SETTLE`=16): a 10-cycle dwell of "8" on an=1110 inserted between valid "5" dwells. Expect digit0=5, and `frame_valid` only after all 4 slots are seen.
- Blank, bad and dp: digit2 = 7'h7F, digit1 = 7'b1111110, digit3 = "A" with dp=0. Expect `blank`=0100, `bad`=0010, `dps`=1000, and digits[15:12]=A.
- Multi-anode: settled dwell with an=1100. Expect a single `an_err` pulse at k+SETTLE+2, `seen` unchanged, no `frame_valid`.
- Stale (`TIMEOUT`=1000): after one frame, hold an=1111. Expect `stale`=1 exactly 1000 cycles after `frame_valid`, and `stale`=0 after the next completed frame.
- Reset mid-frame: capture 3 slots, pulse `reset` 1 cycle, then capture only slot 3. Expect no `frame_valid` and all outputs 0 until 4 fresh slots are captured.

Source files
------------

// File: rtl/seg_capture.sv
// seg_capture: seven-segment scan decoder / display monitor.
//
// Watches the time-multiplexed seg/an/dp display bus. Each anode dwell has
// to hold steady for SETTLE samples before it is accepted. An accepted
// pattern is decoded back to a hex nibble and stored in that digit's shadow
// slot. Once all four slots have been seen, the shadow values are published
// together as one coherent frame.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   seg[6:0]    in   segments a..g, active-low
//   an[3:0]     in   anode enables, active-low, an[0] = rightmost digit
//   dp          in   decimal point, active-low
//   digits[15:0] out frame nibbles, digits[4i+3:4i] = digit i
//   dps[3:0]    out  decimal point lit per digit
//   blank[3:0]  out  digit was fully dark
//   bad[3:0]    out  digit pattern not in decode table
//   frame_valid out  one-cycle pulse when frame outputs update
//   an_err      out  one-cycle pulse on a settled multi-anode dwell
//   stale       out  no frame completed for TIMEOUT cycles
module seg_capture #(
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TIMEOUT = 4_000_000,
    parameter int unsigned TW      = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blank,
    output logic [3:0]  bad,
    output logic        frame_valid,
    output logic        an_err,
    output logic        stale
);

    // Sampled bus: {an, seg, dp}
    logic [11:0]   s_q;
    logic [11:0]   s_p;
    logic [7:0]    cnt;
    logic [3:0]    seen;
    logic [15:0]   sh_digits;
    logic [3:0]    sh_dps;
    logic [3:0]    sh_blank;
    logic [3:0]    sh_bad;
    logic [TW-1:0] stale_cnt;

    logic [3:0] an_low;
    logic [6:0] s_seg;
    logic       s_dp;
    logic       multi;
    logic       one;
    logic       accept;
    logic       capture;
    logic [3:0] dec_nib;
    logic       dec_blank;
    logic       dec_bad;

    assign an_low = ~s_q[11:8];
    assign s_seg  = s_q[7:1];
    assign s_dp   = s_q[0];

    // Clearing the lowest set bit leaves something only if two or more anodes are low.
    assign multi   = (an_low & (an_low - 4'd1)) != 4'd0;
    assign one     = (an_low != 4'd0) && !multi;

    // Fires only on the SETTLE-1 -> SETTLE step, so each dwell is taken once.
    // A bus change in the same cycle cancels it.
    assign accept  = (s_q == s_p) && (cnt == 8'(SETTLE - 1));
    assign capture = accept && one;

    // Active-low gfedcba patterns back to hex.
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (s_seg)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q         <= '0;
            s_p         <= '0;
            cnt         <= '0;
            seen        <= '0;
            sh_digits   <= '0;
            sh_dps      <= '0;
            sh_blank    <= '0;
            sh_bad      <= '0;
            digits      <= '0;
            dps         <= '0;
            blank       <= '0;
            bad         <= '0;
            frame_valid <= 1'b0;
            an_err      <= 1'b0;
            stale_cnt   <= '0;
        end else begin
            s_q <= {an, seg, dp};
            s_p <= s_q;

            if (s_q != s_p) begin
                cnt <= '0;
            end else if (cnt < 8'(SETTLE)) begin
                cnt <= cnt + 8'd1;
            end

            an_err      <= accept && multi;
            frame_valid <= 1'b0;

            for (int i = 0; i < 4; i++) begin
                if (capture && an_low[i]) begin
                    sh_digits[4*i +: 4] <= dec_nib;
                    sh_dps[i]           <= ~s_dp;
                    sh_blank[i]         <= dec_blank;
                    sh_bad[i]           <= dec_bad;
                end
            end

            // The frame publishes one edge after the completing capture.
            if (seen == 4'hF) begin
                digits      <= sh_digits;
                dps         <= sh_dps;
                blank       <= sh_blank;
                bad         <= sh_bad;
                frame_valid <= 1'b1;
                seen        <= capture ? an_low : 4'h0;
            end else if (capture) begin
                seen <= seen | an_low;
            end

            if (frame_valid) begin
                stale_cnt <= '0;
            end else if (stale_cnt != TW'(TIMEOUT)) begin
                stale_cnt <= stale_cnt + TW'(1);
            end
        end
    end

    assign stale = (stale_cnt == TW'(TIMEOUT));

endmodule
